mult_div_unit: RTL and testbench

- Iterative signed multiply/divide unit; the responder side of the control FSM's MultStart/DivStart ↔ mult_done/div_done handshake.
- Latches rs/rt operands on a start pulse and runs one radix-2 step per cycle.
- Presents 64-bit results on hi/lo with a one-cycle done pulse; the control FSM asserts HIWrite/LOWrite in that same cycle.

---
 rtl/mdu_pkg.sv | 17 +
 rtl/mdu_div_step.sv | 22 ++
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared constants and state encoding for the iterative multiply/divide unit.
package mdu_pkg;
   localparam int DATA_W = 32;
   localparam int ITERS  = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MULT = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      MULT = ST_MULT,
      DIV  = ST_DIV,
      DONE = ST_DONE
   } state_t;
endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on magnitudes: shift in the next dividend bit, subtract if it fits.
module mdu_div_step
   import mdu_pkg::*;
(
   input  logic [DATA_W:0]   r,
   input  logic [DATA_W-1:0] qd,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W:0]   r_nxt,
   output logic [DATA_W-1:0] qd_nxt
);
   logic [DATA_W:0] r_sh;

   always_comb begin
      r_sh   = {r[DATA_W-1:0], qd[DATA_W-1]};
      r_nxt  = r_sh;
      qd_nxt = {qd[DATA_W-2:0], 1'b0};
      if (r_sh >= {1'b0, d}) begin
         r_nxt     = r_sh - {1'b0, d};
         qd_nxt[0] = 1'b1;
      end
   end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (Booth radix-2) / divide (restoring) unit, one step per cycle.
//   state | meaning
//   IDLE  | waiting for mult_start / div_start
//   MULT  | Booth steps, 32 cycles
//   DIV   | restoring steps on magnitudes, 32 cycles
//   DONE  | hi/lo valid, matching done pulse for one cycle
module mult_div_unit
   import mdu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              mult_start,
   input  logic              div_start,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              mult_done,
   output logic              div_done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              busy,
   output logic              div_by_zero
);
   state_t state, state_nxt;

   logic [5:0]        cnt;
   logic [DATA_W:0]   acc;
   logic [DATA_W:0]   m_reg;
   logic [DATA_W-1:0] q_reg;
   logic              q_m1;
   logic              op_div;
   logic              sign_q;
   logic              sign_r;
   logic              dbz;
   logic              last_step;

   logic [DATA_W:0]       booth_sum;
   logic [2*DATA_W+1:0]   booth_sh;
   logic [DATA_W:0]       div_r;
   logic [DATA_W-1:0]     div_qd;
   logic [DATA_W-1:0]     abs_a, abs_b, quot, remd;

   assign last_step = (cnt == 6'd0);

   // Magnitude of 0x80000000 is itself when read unsigned, so no special case is needed.
   assign abs_a = op_a[DATA_W-1] ? (~op_a + 1'b1) : op_a;
   assign abs_b = op_b[DATA_W-1] ? (~op_b + 1'b1) : op_b;
   assign quot  = sign_q ? (~div_qd + 1'b1) : div_qd;
   assign remd  = sign_r ? (~div_r[DATA_W-1:0] + 1'b1) : div_r[DATA_W-1:0];

   always_comb begin
      booth_sum = acc;
      case ({q_reg[0], q_m1})
         2'b01:   booth_sum = acc + m_reg;
         2'b10:   booth_sum = acc - m_reg;
         default: booth_sum = acc;
      endcase
      booth_sh = {booth_sum[DATA_W], booth_sum, q_reg};
   end

   mdu_div_step u_div_step (
      .r      (acc),
      .qd     (q_reg),
      .d      (m_reg[DATA_W-1:0]),
      .r_nxt  (div_r),
      .qd_nxt (div_qd)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (mult_start)     state_nxt = MULT;
            else if (div_start) state_nxt = (op_b != '0) ? DIV : DONE;
         end
         MULT:    if (last_step) state_nxt = DONE;
         DIV:     if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         acc    <= '0;
         m_reg  <= '0;
         q_reg  <= '0;
         q_m1   <= 1'b0;
         op_div <= 1'b0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         dbz    <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mult_start) begin
                  acc    <= '0;
                  q_reg  <= op_b;
                  q_m1   <= 1'b0;
                  m_reg  <= {op_a[DATA_W-1], op_a};
                  cnt    <= 6'(ITERS - 1);
                  op_div <= 1'b0;
                  dbz    <= 1'b0;
               end else if (div_start) begin
                  op_div <= 1'b1;
                  if (op_b == '0) begin
                     hi  <= op_a;
                     lo  <= '1;
                     dbz <= 1'b1;
                  end else begin
                     acc    <= '0;
                     q_reg  <= abs_a;
                     m_reg  <= {1'b0, abs_b};
                     sign_q <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
                     sign_r <= op_a[DATA_W-1];
                     cnt    <= 6'(ITERS - 1);
                     dbz    <= 1'b0;
                  end
               end
            end
            MULT: begin
               acc   <= booth_sh[2*DATA_W+1:DATA_W+1];
               q_reg <= booth_sh[DATA_W:1];
               q_m1  <= booth_sh[0];
               if (last_step) begin
                  hi <= booth_sh[2*DATA_W:DATA_W+1];
                  lo <= booth_sh[DATA_W:1];
               end else begin
                  cnt <= cnt - 6'd1;
               end
            end
            DIV: begin
               acc   <= div_r;
               q_reg <= div_qd;
               if (last_step) begin
                  hi <= remd;
                  lo <= quot;
               end else begin
                  cnt <= cnt - 6'd1;
               end
            end
            DONE:    dbz <= 1'b0;
            default: ;
         endcase
      end
   end

   assign busy        = (state != IDLE);
   assign mult_done   = (state == DONE) && !op_div;
   assign div_done    = (state == DONE) && op_div;
   assign div_by_zero = (state == DONE) && dbz;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        mult_start, div_start;
   logic [31:0] op_a, op_b;
   logic        mult_done, div_done, busy, div_by_zero;
   logic [31:0] hi, lo;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   always #5 clk = ~clk;

   mult_div_unit dut (
      .clk         (clk),
      .reset       (reset),
      .mult_start  (mult_start),
      .div_start   (div_start),
      .op_a        (op_a),
      .op_b        (op_b),
      .mult_done   (mult_done),
      .div_done    (div_done),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .div_by_zero (div_by_zero)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed arithmetic, truncating division, architectural corner cases.
   task automatic ref_result(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] rhi, output logic [31:0] rlo, output bit rdbz);
      longint sa, sb, prod;
      logic [63:0] p;
      sa   = longint'(int'(a));
      sb   = longint'(int'(b));
      rdbz = 1'b0;
      if (is_mult) begin
         prod = sa * sb;
         p    = prod;
         rhi  = p[63:32];
         rlo  = p[31:0];
      end else if (b == 32'd0) begin
         rhi  = a;
         rlo  = 32'hFFFF_FFFF;
         rdbz = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         rhi = 32'd0;
         rlo = 32'h8000_0000;
      end else begin
         rlo = 32'(sa / sb);
         rhi = 32'(sa % sb);
      end
   endtask

   // Called just after a negedge with the unit idle. poke_at/reset_at = 0 disables them.
   task automatic run_op(input bit ms, input bit ds, input logic [31:0] a, input logic [31:0] b,
                         input int poke_at, input int reset_at);
      logic [31:0] rhi, rlo;
      bit          rdbz, is_mult, aborted;
      int          lat, last_k;
      logic [3:0]  exp_flags;
      is_mult = ms;
      ref_result(is_mult, a, b, rhi, rlo, rdbz);
      lat    = (!is_mult && b == 32'd0) ? 1 : 33;
      last_k = (reset_at > 0) ? 40 : lat + 1;
      mult_start = ms;
      div_start  = ds;
      op_a = a;
      op_b = b;
      for (int k = 1; k <= last_k; k++) begin
         @(negedge clk);
         aborted = (reset_at > 0) && (k > reset_at);
         if (aborted) begin
            exp_hi = '0;
            exp_lo = '0;
         end else if (k == lat) begin
            exp_hi = rhi;
            exp_lo = rlo;
         end
         exp_flags = aborted ? 4'b0000 :
                     {k <= lat, is_mult && k == lat, !is_mult && k == lat, rdbz && k == lat};
         check($sformatf("flags k=%0d", k), {busy, mult_done, div_done, div_by_zero}, exp_flags);
         check($sformatf("hilo k=%0d", k), {hi, lo}, {exp_hi, exp_lo});
         mult_start = 1'b0;
         div_start  = (k == poke_at);
         reset      = (k == reset_at);
         op_a = $urandom;
         op_b = $urandom;
      end
      div_start = 1'b0;
      reset     = 1'b0;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'(int'($urandom_range(0, 20)) - 10);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] ra, rb;
      bit          rm;
      reset = 1'b1;
      mult_start = 1'b0;
      div_start  = 1'b0;
      op_a = '0;
      op_b = '0;
      repeat (3) @(negedge clk);
      check("reset flags", {busy, mult_done, div_done, div_by_zero}, 4'b0000);
      check("reset hilo", {hi, lo}, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 0, 0);
      run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0, 0);
      run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 0, 0);
      run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      run_op(0, 1, 32'd100, 32'd0, 0, 0);
      run_op(1, 1, 32'd6, 32'd5, 10, 0);
      run_op(1, 0, 32'd123, 32'd456, 0, 10);
      run_op(1, 0, 32'd3, 32'd4, 0, 0);

      for (int i = 0; i < 40; i++) begin
         rm = $urandom_range(0, 1);
         ra = pick_operand();
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : pick_operand();
         run_op(rm, !rm || ($urandom_range(0, 3) == 0), ra, rb, int'($urandom_range(0, 33)), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
